// File: rtl/sum2_accum.sv
// Framed accumulator for the 2-bit adder-tree sum: collects N samples (or fewer on flush)
// and hands the frame total, count and overflow flag downstream. Optional build macro: SUM2_ACCUM_SAT_EN.
module sum2_accum #(
  parameter int ACC_W = 8,
  parameter int N     = 4,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic {ACC, OUT} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, post_acc, sum_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, post_cnt, cnt_out_nxt;
  logic             ovf, ovf_nxt, post_ovf, ovf_out_nxt;
  logic [ACC_W:0]   ext;
  logic             accept, close;

  assign out_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ovf     <= ovf_nxt;
      out_sum <= sum_nxt;
      out_cnt <= cnt_out_nxt;
      out_ovf <= ovf_out_nxt;
    end
  end

  // In OUT the running frame is already cleared, so the same post-accept math
  // starts the next frame when the downstream handshake frees the slot.
  always_comb begin
    in_ready = (state == ACC) ? 1'b1 : out_ready;
    accept   = in_valid & in_ready;
    ext      = {1'b0, acc} + {{(ACC_W-1){1'b0}}, in_data};

    post_acc = acc;
    post_cnt = cnt;
    post_ovf = ovf;
    if (accept) begin
      post_cnt = cnt + CNT_W'(1);
      post_ovf = ovf | ext[ACC_W];
`ifdef SUM2_ACCUM_SAT_EN
      post_acc = ext[ACC_W] ? {ACC_W{1'b1}} : ext[ACC_W-1:0];
`else
      post_acc = ext[ACC_W-1:0];
`endif
    end

    close = (accept && (cnt == CNT_W'(N - 1))) || (flush && (post_cnt != '0));

    state_nxt   = state;
    acc_nxt     = post_acc;
    cnt_nxt     = post_cnt;
    ovf_nxt     = post_ovf;
    sum_nxt     = out_sum;
    cnt_out_nxt = out_cnt;
    ovf_out_nxt = out_ovf;

    case (state)
      ACC: begin
        if (close) state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) state_nxt = close ? OUT : ACC;
      end
      default: state_nxt = ACC;
    endcase

    if (close && (state == ACC || out_ready)) begin
      sum_nxt     = post_acc;
      cnt_out_nxt = post_cnt;
      ovf_out_nxt = post_ovf;
      acc_nxt     = '0;
      cnt_nxt     = '0;
      ovf_nxt     = 1'b0;
    end
  end

endmodule

// File: tb/tb_sum2_accum.sv
// Bench for sum2_accum: three instances (8b/N=4, 3b/N=4, 8b/N=2) share the stimulus and are
// compared against a frame-level model that tracks true integer totals per frame.
module tb_sum2_accum;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_data = 2'd0;

  always #5 clk = ~clk;

  logic       ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [7:0] sum0, sum2;
  logic [2:0] sum1;
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;

  sum2_accum #(.ACC_W(8), .N(4)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
    .out_cnt(cnt0), .out_ovf(of0));

  sum2_accum #(.ACC_W(3), .N(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
    .out_cnt(cnt1), .out_ovf(of1));

  sum2_accum #(.ACC_W(8), .N(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .flush(flush), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
    .out_cnt(cnt2), .out_ovf(of2));

  int checks = 0;
  int errors = 0;

  int mw[3] = '{8, 3, 8};
  int mn[3] = '{4, 4, 2};
  bit hold[3];
  int fcnt[3], ftot[3], esum[3], ecnt[3];
  bit eovf[3];

  function automatic int observed(int i, int which);
    logic [4:0] ir, ov, ofl;
    int s, c;
    ir  = {2'b0, ir2, ir1, ir0};
    ov  = {2'b0, ov2, ov1, ov0};
    ofl = {2'b0, of2, of1, of0};
    s = (i == 0) ? int'(sum0) : (i == 1) ? int'(sum1) : int'(sum2);
    c = (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
    case (which)
      0: return int'(ir[i]);
      1: return int'(ov[i]);
      2: return s;
      3: return c;
      default: return int'(ofl[i]);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame-level reference: the expected sum comes from the exact integer total of the frame.
  task automatic modelStep(input bit v, input int d, input bit f, input bit r, input bit rst);
    int maxv;
    bit rdy, acc;
    for (int i = 0; i < 3; i++) begin
      maxv = (1 << mw[i]) - 1;
      rdy  = !hold[i] || r;
      acc  = v && rdy;
      if (rst) begin
        hold[i] = 0; fcnt[i] = 0; ftot[i] = 0;
        esum[i] = 0; ecnt[i] = 0; eovf[i] = 0;
      end else begin
        if (hold[i] && r) hold[i] = 0;
        if (acc) begin
          fcnt[i]++;
          ftot[i] += d;
        end
        if ((acc && fcnt[i] == mn[i]) || (f && fcnt[i] > 0)) begin
`ifdef SUM2_ACCUM_SAT_EN
          esum[i] = (ftot[i] > maxv) ? maxv : ftot[i];
`else
          esum[i] = ftot[i] % (maxv + 1);
`endif
          ecnt[i] = fcnt[i];
          eovf[i] = (ftot[i] > maxv);
          hold[i] = 1;
          fcnt[i] = 0;
          ftot[i] = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]", i), observed(i, 1), int'(hold[i]));
      if (hold[i]) begin
        chk($sformatf("out_sum[%0d]", i), observed(i, 2), esum[i]);
        chk($sformatf("out_cnt[%0d]", i), observed(i, 3), ecnt[i]);
        chk($sformatf("out_ovf[%0d]", i), observed(i, 4), int'(eovf[i]));
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit f, input bit r, input bit rst);
    in_valid  = v;
    in_data   = 2'(d);
    flush     = f;
    out_ready = r;
    reset     = rst;
    #1;
    if (!rst)
      for (int i = 0; i < 3; i++)
        chk($sformatf("in_ready[%0d]", i), observed(i, 0), int'(!hold[i] || r));
    @(posedge clk);
    modelStep(v, d, f, r, rst);
    #1;
    checkOutput();
  endtask

  task automatic checkReset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid[%0d]", i), observed(i, 1), 0);
      chk($sformatf("rst_sum[%0d]", i), observed(i, 2), 0);
      chk($sformatf("rst_cnt[%0d]", i), observed(i, 3), 0);
      chk($sformatf("rst_ovf[%0d]", i), observed(i, 4), 0);
    end
  endtask

  initial begin
    int seen;
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkReset();

    $display("[TB] basic frame");
    applyStimulus(1, 3, 0, 1, 0);
    applyStimulus(1, 3, 0, 1, 0);
    applyStimulus(1, 2, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0);
    chk("t1_valid", int'(ov0), 1);
    chk("t1_sum", int'(sum0), 9);
    chk("t1_cnt", int'(cnt0), 4);
    chk("t1_ovf", int'(of0), 0);
    applyStimulus(0, 0, 0, 1, 0);
    chk("t1_valid_drop", int'(ov0), 0);

    $display("[TB] overflow");
    applyStimulus(0, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) applyStimulus(1, 3, 0, 1, 0);
`ifdef SUM2_ACCUM_SAT_EN
    chk("t2_sum", int'(sum1), 7);
`else
    chk("t2_sum", int'(sum1), 4);
`endif
    chk("t2_ovf", int'(of1), 1);
    chk("t2_sum_wide", int'(sum0), 12);

    $display("[TB] backpressure");
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 2, 0, 1, 0);
    applyStimulus(1, 3, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 3, 0, 0, 0);
      chk("t3_hold_sum", int'(sum0), 6);
      chk("t3_ready", int'(ir0), 0);
    end
    applyStimulus(1, 2, 0, 1, 0);
    chk("t3_next_valid", int'(ov0), 0);
    applyStimulus(1, 2, 1, 1, 0);
    chk("t3_next_sum", int'(sum0), 4);
    chk("t3_next_cnt", int'(cnt0), 2);

    $display("[TB] flush");
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(1, 2, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    chk("t4_sum", int'(sum0), 3);
    chk("t4_cnt", int'(cnt0), 2);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    chk("t4_empty_flush", int'(ov0), 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 3, 0, 1, 0);
    applyStimulus(1, 3, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 0, 1, 0);
      if (ov0) seen++;
    end
    chk("t5_results", seen, 1);
    chk("t5_sum", int'(sum0), 4);
    chk("t5_cnt", int'(cnt0), 4);

    $display("[TB] back-to-back");
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 2, 0, 1, 0);
    chk("t6_sum_a", int'(sum2), 3);
    applyStimulus(1, 3, 0, 1, 0);
    chk("t6_ready", int'(ir2), 1);
    applyStimulus(1, 0, 0, 1, 0);
    chk("t6_sum_b", int'(sum2), 3);
    chk("t6_valid_b", int'(ov2), 1);

    $display("[TB] random");
    for (int k = 0; k < 400; k++)
      applyStimulus($urandom_range(3) != 0, int'($urandom_range(3)), $urandom_range(9) == 0,
                    $urandom_range(9) < 7, $urandom_range(49) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
